// File: rtl/conv_encoder_pkg.sv
// conv_pkg: generators, rate encodings, puncture tables and FSM states for conv_encoder.
package conv_pkg;
  localparam logic [6:0] GEN_A = 7'o133;
  localparam logic [6:0] GEN_B = 7'o171;
  localparam logic [1:0] RATE_1_2 = 2'b00;
  localparam logic [1:0] RATE_2_3 = 2'b01;
  localparam logic [1:0] RATE_3_4 = 2'b10;
  localparam logic [1:0] KEEP_AB = 2'b11;
  localparam logic [1:0] KEEP_A = 2'b10;
  localparam logic [1:0] KEEP_B = 2'b01;
  typedef enum logic [1:0] {EMPTY, EMIT_A, EMIT_B} state_t;
  // Tap vector is {current input, delay1 .. delay6}, so the generator MSB taps the current bit.
  function automatic logic parity(input logic [6:0] g, input logic [6:0] v);
    return ^(g & v);
  endfunction
  function automatic logic [1:0] period(input logic [1:0] r);
    return r == RATE_2_3 ? 2'd2 : r == RATE_3_4 ? 2'd3 : 2'd1;
  endfunction
  function automatic logic [1:0] keep_mask(input logic [1:0] r, input logic [1:0] ph);
    return r == RATE_2_3 ? (ph == 2'd1 ? KEEP_A : KEEP_AB) :
           r == RATE_3_4 ? (ph == 2'd1 ? KEEP_A : ph == 2'd2 ? KEEP_B : KEEP_AB) : KEEP_AB;
  endfunction
endpackage

// File: rtl/conv_encoder_if.sv
// conv_encoder_if: single-bit valid/ready stream.
interface conv_encoder_if;
  logic data;
  logic valid;
  logic ready;
  modport master (output data, valid, input ready);
  modport slave (input data, valid, output ready);
endinterface

// File: rtl/conv_encoder_serializer.sv
// conv_puncture_serializer: holds one coded pair and emits its kept bits one per handshake.
module conv_puncture_serializer
  import conv_pkg::*;
(
  input logic clk,
  input logic rst_n,
  input logic flush,
  input logic load,
  input logic a,
  input logic b,
  input logic [1:0] keep,
  output logic ready,
  conv_encoder_if.master out_s
);
  state_t state_q, state_d;
  logic b_q, b_next_q, data_q, data_d, a_to_b, last;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      b_q <= 1'b0;
      b_next_q <= 1'b0;
      data_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      if (load) begin
        b_q <= b;
        b_next_q <= &keep;
      end
    end
  end
  // A load always wins over a flush: a bit accepted with Start belongs to the new PPDU.
  always_comb begin
    a_to_b = state_q == EMIT_A && out_s.ready && b_next_q;
    state_d = load ? (keep[1] ? EMIT_A : EMIT_B) : flush ? EMPTY : a_to_b ? EMIT_B :
              (state_q != EMPTY && out_s.ready) ? EMPTY : state_q;
    data_d = load ? (keep[1] ? a : b) : flush ? 1'b0 : a_to_b ? b_q : data_q;
  end
  always_comb begin
    last = state_q == EMIT_B || (state_q == EMIT_A && !b_next_q);
    ready = state_q == EMPTY || (last && out_s.ready);
    out_s.valid = state_q != EMPTY;
    out_s.data = data_q;
  end
endmodule

// File: rtl/conv_encoder.sv
// conv_encoder: 802.11a K=7 convolutional encoder; puncturing to 2/3 and 3/4 when CONV_PUNCTURE_EN is defined.
module conv_encoder
  import conv_pkg::*;
(
  input logic clk,
  input logic rst_n,
  input logic start,
  input logic [1:0] rate,
  conv_encoder_if.slave in_s,
  conv_encoder_if.master out_s
);
  logic [5:0] sr_q, sr_c;
  logic [1:0] keep;
  logic accept, ready;
  assign sr_c = start ? 6'd0 : sr_q;
  assign accept = in_s.valid && ready;
  assign in_s.ready = ready;
  always_ff @(posedge clk) begin
    if (!rst_n) sr_q <= 6'd0;
    else if (accept) sr_q <= {in_s.data, sr_c[5:1]};
    else if (start) sr_q <= 6'd0;
  end
`ifdef CONV_PUNCTURE_EN
  logic [1:0] rate_q, phase_q, rate_c, phase_c;
  assign rate_c = start ? rate : rate_q;
  assign phase_c = start ? 2'd0 : phase_q;
  assign keep = keep_mask(rate_c, phase_c);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rate_q <= RATE_1_2;
      phase_q <= 2'd0;
    end else begin
      if (start) rate_q <= rate;
      if (accept) phase_q <= (phase_c + 2'd1 == period(rate_c)) ? 2'd0 : phase_c + 2'd1;
      else if (start) phase_q <= 2'd0;
    end
  end
`else
  logic unused_rate;
  assign unused_rate = ^rate;
  assign keep = KEEP_AB;
`endif
  conv_puncture_serializer ser (
    .clk(clk),
    .rst_n(rst_n),
    .flush(start),
    .load(accept),
    .a(parity(GEN_A, {in_s.data, sr_c})),
    .b(parity(GEN_B, {in_s.data, sr_c})),
    .keep(keep),
    .ready(ready),
    .out_s(out_s)
  );
endmodule

// File: tb/tb_conv_encoder.sv
// tb_conv_encoder: directed and random checks of conv_encoder against a history-based encoder model.
module tb_conv_encoder;
  localparam logic [6:0] GA = 7'o133;
  localparam logic [6:0] GB = 7'o171;
`ifdef CONV_PUNCTURE_EN
  localparam bit PUNCT = 1'b1;
`else
  localparam bit PUNCT = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [1:0] rate = 2'd0;
  conv_encoder_if in_if ();
  conv_encoder_if out_if ();
  conv_encoder dut (.clk(clk), .rst_n(rst_n), .start(start), .rate(rate), .in_s(in_if), .out_s(out_if));
  always #5 clk = ~clk;
  int errors = 0, checks = 0, nout = 0, m_rate = 0;
  bit hist[$];
  bit exp_q[$];
  logic [31:0] got = '0;
  bit seen_valid, seen_data, seen_ready, last_acc;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_start(int r);
    hist.delete();
    exp_q.delete();
    m_rate = PUNCT ? r : 0;
  endtask
  // Coded bit n is the generator-weighted XOR of input n and the six inputs before it.
  task automatic model_push(bit d);
    int n, p, ph;
    bit a, b;
    hist.push_back(d);
    n = hist.size() - 1;
    a = 0;
    b = 0;
    for (int k = 0; k < 7; k++)
      if (n - k >= 0) begin
        a ^= GA[6-k] & hist[n-k];
        b ^= GB[6-k] & hist[n-k];
      end
    p = m_rate == 1 ? 2 : m_rate == 2 ? 3 : 1;
    ph = n % p;
    if (!(p == 3 && ph == 2)) exp_q.push_back(a);
    if (p == 1 || ph != 1) exp_q.push_back(b);
  endtask
  task automatic step(bit v, bit d, bit r, bit s);
    bit e;
    @(negedge clk);
    in_if.valid = v;
    in_if.data = d;
    out_if.ready = r;
    start = s;
    #1;
    seen_valid = out_if.valid;
    seen_data = out_if.data;
    seen_ready = in_if.ready;
    last_acc = v && seen_ready;
    if (seen_valid && r) begin
      got = {got[30:0], seen_data};
      nout++;
      if (exp_q.size() == 0) chk("out_extra", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        chk("out_data", seen_data, e);
      end
    end
    if (s) model_start(rate);
    if (last_acc) model_push(d);
  endtask
  task automatic begin_ppdu(logic [1:0] r);
    rate = r;
    step(0, 0, 1, 1);
    got = '0;
    nout = 0;
  endtask
  task automatic feed(bit d);
    last_acc = 0;
    for (int i = 0; i < 32 && !last_acc; i++) step(1, d, 1, 0);
    if (!last_acc) chk("feed_timeout", 0, 1);
  endtask
  task automatic drain(string tag);
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) step(0, 0, 1, 0);
    chk({tag, "_drained"}, exp_q.size(), 0);
    step(0, 0, 1, 0);
  endtask
  initial begin
    int base;
    bit d0;
    in_if.valid = 0;
    in_if.data = 0;
    out_if.ready = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", out_if.valid, 0);
    chk("rst_out_data", out_if.data, 0);
    chk("rst_in_ready", in_if.ready, 1);
    rst_n = 1;
    begin_ppdu(0);
    for (int k = 0; k < 32; k++) begin
      step(1, 0, 1, 0);
      chk("s1_in_ready", seen_ready, (k % 2 == 0) ? 1 : 0);
    end
    drain("s1");
    chk("s1_count", nout, 32);
    begin_ppdu(0);
    feed(1);
    repeat (6) feed(0);
    drain("s2");
    chk("s2_impulse", got[13:0], 14'b11011111001011);
    begin_ppdu(2);
    repeat (3) feed(1);
    drain("s3");
    chk("s3_count", nout, PUNCT ? 4 : 6);
    base = nout;
    feed(0);
    drain("s3_phase");
    chk("s3_phase_wrap", nout - base, 2);
    begin_ppdu(1);
    repeat (4) feed(1'($urandom));
    for (int k = 0; k < 5; k++) begin
      step(1, 1'($urandom), 0, 0);
      if (k == 0) d0 = seen_data;
      chk("s4_valid_held", seen_valid, 1);
      chk("s4_data_held", seen_data, d0);
      chk("s4_in_ready", seen_ready, 0);
    end
    repeat (20) step(1'($urandom), 1'($urandom), 1, 0);
    drain("s4");
    begin_ppdu(0);
    feed(1);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    chk("s5_flushed", seen_valid, 0);
    got = '0;
    nout = 0;
    feed(1);
    drain("s5");
    chk("s5_zero_state", got[1:0], 2'b11);
    chk("s5_count", nout, 2);
    begin_ppdu(0);
    repeat (3) feed(1'($urandom));
    rst_n = 0;
    step(0, 0, 0, 0);
    model_start(0);
    @(negedge clk);
    rst_n = 1;
    step(0, 0, 1, 0);
    chk("s6_out_valid", seen_valid, 0);
    chk("s6_in_ready", seen_ready, 1);
    got = '0;
    nout = 0;
    feed(1);
    repeat (6) feed(0);
    drain("s6");
    chk("s6_impulse", got[13:0], 14'b11011111001011);
    for (int r = 0; r < 4; r++) begin
      begin_ppdu(2'(r));
      repeat (250) step(1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), 0);
      drain("rand");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
